instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Owns the PC, drives word-aligned byte addresses to the combinational instruction memory, and captures each returned word into a small prefetch FIFO. Presents {instruction, pc, pc+4} to the decode stage over a valid/ready handshake. Supports branch redirect/flush and stops fetching at the end of the program image.

Parameters:
ADDR_W, 32, PC / address width in bits
RESET_PC, 0, PC value loaded on reset (byte address, multiple of 4)
PROG_BYTES, 28, program image size in bytes; fetch stops when pc >= PROG_BYTES
DEPTH, 2, prefetch FIFO entries (power of 2, >= 2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
imem_address  out  ADDR_W  byte address to instruction memory, equals pc
imem_instruction  in  32  word returned combinationally for imem_address
branch_taken  in  1  redirect request from downstream, single-cycle pulse
branch_addr  in  ADDR_W  redirect target byte address
out_valid  out  1  FIFO head holds a valid instruction
out_ready  in  1  decode accepts head this cycle
out_instruction  out  32  FIFO head instruction
out_pc  out  ADDR_W  byte address of head instruction
out_pc_plus4  out  ADDR_W  out_pc + 4, wraps modulo 2^ADDR_W
fifo_count  out  $clog2(DEPTH)+1  occupied entries
halted  out  1  pc >= PROG_BYTES and fifo_count == 0

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, FIFO pointers and count=0, all FIFO entries cleared to 0; hence out_valid=0, out_instruction=0, out_pc=0, out_pc_plus4=4, fifo_count=0; halted=1 only if RESET_PC >= PROG_BYTES.
- imem_address = pc, combinational from register; bits [1:0] always 0.
- pop = out_valid & out_ready.
- push = !branch_taken & (pc < PROG_BYTES) & (fifo_count < DEPTH | pop).
- On push: entry {imem_instruction, pc} written at tail, pc <= pc + 4. Full with simultaneous pop: push and pop both occur, count unchanged.
- Latency: instruction at address A becomes visible at FIFO head the cycle after it is addressed, if FIFO empty; no combinational path from imem_instruction to out_*.
- out_* driven from head entry registers; stable while out_valid=1 and out_ready=0.
- Redirect (branch_taken=1), highest priority: pc <= {branch_addr[ADDR_W-1:2], 2'b00}; FIFO flushed (count=0, pointers reset) at the same edge; no push that cycle. A pop coinciding with branch_taken counts as consumed by decode; all other entries are discarded.
- End of program: when pc >= PROG_BYTES, no further pushes; FIFO drains normally. halted asserts once drained. A redirect to an address < PROG_BYTES clears halted next cycle and resumes fetch.
- pc increment wraps modulo 2^ADDR_W; no overflow flag.
- Reset asserted mid-operation: immediate return to reset state regardless of handshake in progress; in-flight entries lost.
- FIFO never overflows: push is gated by count. It never underflows: pop requires out_valid.

Test Plan:
Bench memory model holds W0..W6 = 0x00220000, 0x00640000, 0x00A60000, 0x00E81000, 0x01281800, 0x016C0000, 0x01AE0000.
- Reset release, out_ready=1 constant -> out_valid rises 1 cycle after release; W0..W6 emitted on consecutive cycles with out_pc 0,4,...,24; then out_valid=0 and halted=1; imem_address holds 28.
- out_ready=0 for 5 cycles after reset -> fifo_count saturates at 2, imem_address holds 8, head stays W0/pc 0; release ready -> W0,W1,W2... in order with no gap or duplicate.
- branch_taken with branch_addr=0x0E while head=W1 is popped -> next out_valid shows out_pc=12, W3; W2 never emitted; fifo_count=0 on the cycle after the redirect.
- After halted, pulse branch_taken with branch_addr=4 -> halted deasserts next cycle; W1..W6 re-emitted.
- Full FIFO with out_ready toggling every cycle -> count stays within 1..2 and sequence is strictly increasing by 4.
- Assert rst for 1 cycle mid-stream with fifo_count=2 -> outputs return to reset values asynchronously; fetch restarts at W0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads the combinational
// instruction memory one word per cycle, and buffers {instruction, pc}
// pairs in a small prefetch FIFO that is presented to decode over a
// valid/ready handshake. A branch redirect flushes the FIFO and reloads the
// pc. Fetching stops once the pc leaves the program image.
module instruction_fetch_unit #(
    parameter int ADDR_W     = 32,
    parameter int RESET_PC   = 0,
    parameter int PROG_BYTES = 28,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          imem_address,
    input  logic [31:0]                imem_instruction,
    input  logic                       branch_taken,
    input  logic [ADDR_W-1:0]          branch_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instruction,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_pc_plus4,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Word alignment mask: clears the two byte-offset bits of an address.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] PROG_END   = ADDR_W'(PROG_BYTES);
    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC) & ALIGN_MASK;
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};

    // Architectural state.
    logic [ADDR_W-1:0] pc_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [31:0]       fifo_instr_r [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_r    [DEPTH];

    // Next-state and handshake signals.
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [PTR_W-1:0]  wr_ptr_nxt_s;
    logic [PTR_W-1:0]  rd_ptr_nxt_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              out_valid_s;
    logic              pop_s;
    logic              push_s;
    logic              in_program_s;
    logic              has_room_s;
    logic [ADDR_W-1:0] redirect_pc_s;

    // Handshake decode: a slot frees up either from spare capacity or from a
    // pop in the same cycle, so a full FIFO still streams at one word/cycle.
    always_comb begin
        out_valid_s   = (count_r != CNT_ZERO);
        pop_s         = out_valid_s & out_ready;
        in_program_s  = (pc_r < PROG_END);
        has_room_s    = (count_r < CNT_FULL) | pop_s;
        push_s        = ~branch_taken & in_program_s & has_room_s;
        redirect_pc_s = branch_addr & ALIGN_MASK;
    end

    // Next-state logic: a redirect overrides fetch and flushes the FIFO; a
    // pop in the same cycle is simply absorbed by the flush.
    always_comb begin
        pc_nxt_s     = pc_r;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (branch_taken) begin
            pc_nxt_s     = redirect_pc_s;
            wr_ptr_nxt_s = PTR_ZERO;
            rd_ptr_nxt_s = PTR_ZERO;
            count_nxt_s  = CNT_ZERO;
        end else begin
            if (push_s) begin
                pc_nxt_s     = pc_r + PC_STEP;
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                pc_nxt_s     = pc_r;
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Control registers: pc, FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r     <= RESET_PC_A;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            pc_r     <= pc_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // FIFO storage: captures the fetched word and its pc at the tail; cleared
    // on reset so the head outputs read as zero until the first fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_r[i] <= 32'h0000_0000;
                fifo_pc_r[i]    <= {ADDR_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_instr_r[wr_ptr_r] <= imem_instruction;
            fifo_pc_r[wr_ptr_r]    <= pc_r;
        end
    end

    // Outputs come straight from registers; imem_instruction only reaches
    // them through the FIFO storage, so there is no combinational path.
    always_comb begin
        imem_address    = pc_r;
        out_valid       = out_valid_s;
        out_instruction = fifo_instr_r[rd_ptr_r];
        out_pc          = fifo_pc_r[rd_ptr_r];
        out_pc_plus4    = fifo_pc_r[rd_ptr_r] + PC_STEP;
        fifo_count      = count_r;
        halted          = ~in_program_s & ~out_valid_s;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: a cycle table checks timing-visible
// outputs while a scoreboard checks the order and content of every word
// accepted by decode; a few hand-written sequences cover ready toggling and
// mid-stream reset.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [1:0]  fifo_count;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wmem [7];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        bit          rst;
        bit          ready;
        bit          br;
        logic [31:0] baddr;
        bit          reload;
        logic [31:0] reload_pc;
        bit          exp_valid;
        logic [31:0] exp_pc;
        logic [1:0]  exp_cnt;
        bit          exp_halted;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vecs[$];

    instruction_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .branch_taken     (branch_taken),
        .branch_addr      (branch_addr),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .out_pc_plus4     (out_pc_plus4),
        .fifo_count       (fifo_count),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory holding the 7-word program image.
    always_comb begin
        if (imem_address < 32'd28) imem_instruction = wmem[imem_address[4:2]];
        else                       imem_instruction = 32'h0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic reload_sb(input logic [31:0] start);
        sb.delete();
        for (int a = int'(start); a < 28; a += 4) begin
            sb_t e;
            e.instr = wmem[a / 4];
            e.pc    = 32'(a);
            sb.push_back(e);
        end
    endtask

    // Called just before an edge: if decode accepts the head, compare it
    // against the next expected word.
    task automatic consume();
        sb_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(out_pc), 64'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("head_instr", 64'(out_instruction), 64'(e.instr));
                chk("head_pc",    64'(out_pc),          64'(e.pc));
                chk("head_pc4",   64'(out_pc_plus4),    64'(e.pc + 32'd4));
            end
        end
    endtask

    task automatic add(input bit r, input bit rdy, input bit br, input logic [31:0] ba,
                       input bit rl, input logic [31:0] rpc, input bit ev,
                       input logic [31:0] epc, input logic [1:0] ecnt, input bit eh,
                       input logic [31:0] eaddr);
        vec_t v;
        v.rst = r; v.ready = rdy; v.br = br; v.baddr = ba;
        v.reload = rl; v.reload_pc = rpc;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_cnt = ecnt;
        v.exp_halted = eh; v.exp_addr = eaddr;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_pc;
        bit          have_last;
        bit          done;

        wmem[0] = 32'h0022_0000; wmem[1] = 32'h0064_0000; wmem[2] = 32'h00A6_0000;
        wmem[3] = 32'h00E8_1000; wmem[4] = 32'h0128_1800; wmem[5] = 32'h016C_0000;
        wmem[6] = 32'h01AE_0000;

        // Streaming with ready held high, then drain to halt.
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'd0);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'd0);
        for (int k = 1; k <= 7; k++)
            add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'(4*(k-1)), 2'd1, 1'b0, 32'(4*k));
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1, 32'd28);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1, 32'd28);
        // Backpressure fills the FIFO; then a redirect to 0x0E while W1 pops.
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0, 32'd0);
        add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'd0, 2'd1, 1'b0, 32'd4);
        for (int k = 0; k < 4; k++)
            add(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'd0, 2'd2, 1'b0, 32'd8);
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'd4, 2'd2, 1'b0, 32'd12);
        add(1'b1, 1'b1, 1'b1, 32'h0E, 1'b1, 32'd12, 1'b0, 32'h0, 2'd0, 1'b0, 32'd12);
        for (int p = 12; p <= 24; p += 4)
            add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'(p), 2'd1, 1'b0, 32'(p+4));
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1, 32'd28);
        // Redirect out of the halted state to address 4.
        add(1'b1, 1'b1, 1'b1, 32'd4, 1'b1, 32'd4, 1'b0, 32'h0, 2'd0, 1'b0, 32'd4);
        for (int p = 4; p <= 24; p += 4)
            add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'(p), 2'd1, 1'b0, 32'(p+4));
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1, 32'd28);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            rst          = v.rst;
            out_ready    = v.ready;
            branch_taken = v.br;
            branch_addr  = v.baddr;
            #1;
            consume();
            if (v.reload) begin
                if (!v.rst) chk("sb_empty_at_reset", 64'(sb.size()), 64'd0);
                reload_sb(v.reload_pc);
            end
            @(posedge clk); #1;
            chk("out_valid",    64'(out_valid),    64'(v.exp_valid));
            if (v.exp_valid) chk("out_pc", 64'(out_pc), 64'(v.exp_pc));
            chk("fifo_count",   64'(fifo_count),   64'(v.exp_cnt));
            chk("halted",       64'(halted),       64'(v.exp_halted));
            chk("imem_address", 64'(imem_address), 64'(v.exp_addr));
            if (!v.rst) begin
                chk("rst_instr", 64'(out_instruction), 64'd0);
                chk("rst_pc",    64'(out_pc),          64'd0);
                chk("rst_pc4",   64'(out_pc_plus4),    64'd4);
            end
        end
        branch_taken = 1'b0;
        chk("sb_empty_after_table", 64'(sb.size()), 64'd0);

        // Fill the FIFO, then toggle ready every cycle.
        rst = 1'b0; out_ready = 1'b0;
        reload_sb(32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("fill_count", 64'(fifo_count), 64'd2);
        have_last = 1'b0;
        last_pc   = 32'h0;
        for (int c = 0; c < 8; c++) begin
            out_ready = (c % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                if (have_last) chk("pc_step", 64'(out_pc), 64'(last_pc + 32'd4));
                last_pc   = out_pc;
                have_last = 1'b1;
            end
            consume();
            @(posedge clk); #1;
            chk("cnt_range", 64'(fifo_count >= 2'd1 && fifo_count <= 2'd2), 64'd1);
        end
        chk("pre_reset_count", 64'(fifo_count), 64'd2);

        // Asynchronous reset mid-stream, away from any clock edge.
        #2;
        rst = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid),       64'd0);
        chk("async_count", 64'(fifo_count),      64'd0);
        chk("async_addr",  64'(imem_address),    64'd0);
        chk("async_instr", 64'(out_instruction), 64'd0);
        chk("async_pc",    64'(out_pc),          64'd0);
        chk("async_pc4",   64'(out_pc_plus4),    64'd4);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        reload_sb(32'd0);
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            #1;
            consume();
            @(posedge clk); #1;
            if (halted) done = 1'b1;
        end
        chk("restart_halt", 64'(halted), 64'd1);
        chk("restart_drain", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
